// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: PC sequencing, imem handshake, 1-entry hold, redirect/drop
// Optional build macro: FETCH_SUPERVISOR_PROTECT_EN (bit 31 acts as a supervisor flag)
module fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] pc_plus_four,
  output logic        inst_valid
);

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] NOP          = 32'h83FF_F800;
  localparam logic [31:0] ILLOP_ADDR   = 32'h8000_0004;
  localparam logic [31:0] XADR_ADDR    = 32'h8000_0008;

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_word;
  logic        busy;
  logic        orphan;
  logic        orphan_drop;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;

  // pc_sel 1..4 are redirects; 0 and 5..7 mean sequential fetch
  assign redirect    = (pc_sel >= 3'd1) && (pc_sel <= 3'd4);
  // a request left outstanding across reset must have its ack swallowed
  assign orphan_drop = orphan & busy;
  assign imem_req    = ~rst & (state == S_FETCH) & ~orphan_drop;
  assign imem_addr   = pc;

  // next sequential PC and redirect target selection
  always_comb begin
    target = RESET_VECTOR;
`ifdef FETCH_SUPERVISOR_PROTECT_EN
    // supervisor bit survives increments; user code cannot jump into supervisor space
    pc_inc = ((pc + 32'd4) & 32'h7FFF_FFFF) | (pc & 32'h8000_0000);
    case (pc_sel)
      3'd1:    target = (branch_addr & 32'h7FFF_FFFC) | (pc & 32'h8000_0000);
      3'd2:    target = (jump_addr & 32'h7FFF_FFFC) | ({pc[31] & jump_addr[31], 31'd0});
      3'd3:    target = ILLOP_ADDR;
      3'd4:    target = XADR_ADDR;
      default: target = pc_inc;
    endcase
`else
    pc_inc = pc + 32'd4;
    case (pc_sel)
      3'd1:    target = branch_addr & 32'hFFFF_FFFC;
      3'd2:    target = jump_addr & 32'hFFFF_FFFC;
      3'd3:    target = ILLOP_ADDR;
      3'd4:    target = XADR_ADDR;
      default: target = pc_inc;
    endcase
`endif
  end

  // outstanding-request tracker; deliberately not reset so it spans a reset pulse
  always_ff @(posedge clk) begin
    busy <= (busy | imem_req) & ~imem_ack;
  end

  // fetch state machine with registered decode-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_FETCH;
      pc           <= RESET_VECTOR;
      hold_word    <= 32'd0;
      inst         <= NOP;
      pc_plus_four <= RESET_VECTOR;
      inst_valid   <= 1'b0;
      orphan       <= 1'b1;
    end else begin
      orphan <= orphan & busy & ~imem_ack;
      // decode consumed the current word: bubble unless something new loads below
      if (!stall) begin
        inst_valid <= 1'b0;
        inst       <= NOP;
      end
      case (state)
        S_FETCH: begin
          if (orphan_drop) begin
            // waiting out the pre-reset ack; no request is on the bus
            if (redirect) begin
              pc         <= target;
              inst_valid <= 1'b0;
              inst       <= NOP;
            end
          end else if (redirect) begin
            pc         <= target;
            inst_valid <= 1'b0;
            inst       <= NOP;
            state      <= imem_ack ? S_FETCH : S_DROP;
          end else if (imem_ack) begin
            if (!stall) begin
              inst         <= imem_rdata;
              pc_plus_four <= pc_inc;
              inst_valid   <= 1'b1;
              pc           <= pc_inc;
            end else begin
              hold_word <= imem_rdata;
              state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc         <= target;
            inst_valid <= 1'b0;
            inst       <= NOP;
            hold_word  <= 32'd0;
            state      <= S_FETCH;
          end else if (!stall) begin
            inst         <= hold_word;
            pc_plus_four <= pc_inc;
            inst_valid   <= 1'b1;
            pc           <= pc_inc;
            hold_word    <= 32'd0;
            state        <= S_FETCH;
          end
        end
        S_DROP: begin
          if (redirect) begin
            pc         <= target;
            inst_valid <= 1'b0;
            inst       <= NOP;
          end
          if (imem_ack) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed self-checking bench for fetch
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [2:0]  pc_sel;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc_plus_four;
  logic        inst_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h83FF_F800;
`ifdef FETCH_SUPERVISOR_PROTECT_EN
  localparam logic [31:0] EXP_BRANCH = 32'h8000_0100;
  localparam logic [31:0] EXP_JUMP   = 32'h0000_0010;
  localparam logic [31:0] EXP_WRAP   = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_BRANCH = 32'h0000_0100;
  localparam logic [31:0] EXP_JUMP   = 32'h8000_0010;
  localparam logic [31:0] EXP_WRAP   = 32'h8000_0000;
`endif

  fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel),
    .branch_addr(branch_addr), .jump_addr(jump_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .pc_plus_four(pc_plus_four), .inst_valid(inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; imem_ack = 1'b1; stall = 1'b0; pc_sel = 3'd0;
    tick;
    imem_ack = 1'b0;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; stall = 1'b0; pc_sel = 3'd0; imem_ack = 1'b0;
    imem_rdata = 32'd0; branch_addr = 32'd0; jump_addr = 32'd0;
    #1 rst = 1'b1;
    tick; tick;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    checks++; if (inst !== NOP) begin errors++; $display("FAIL reset_inst: got %h expected %h", inst, NOP); end
    checks++; if (pc_plus_four !== 32'h8000_0000) begin errors++; $display("FAIL reset_ppf: got %h expected 80000000", pc_plus_four); end
    checks++; if (imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr: got %h expected 80000000", imem_addr); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_stream;
    do_reset;
    imem_ack = 1'b1; imem_rdata = 32'h1111_0000;
    #1;
    checks++; if (imem_addr !== 32'h8000_0000) begin errors++; $display("FAIL stream_addr0: got %h expected 80000000", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_valid0: got %b expected 0", inst_valid); end
    tick;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid1: got %b expected 1", inst_valid); end
    checks++; if (inst !== 32'h1111_0000) begin errors++; $display("FAIL stream_inst1: got %h expected 11110000", inst); end
    checks++; if (pc_plus_four !== 32'h8000_0004) begin errors++; $display("FAIL stream_ppf1: got %h expected 80000004", pc_plus_four); end
    checks++; if (imem_addr !== 32'h8000_0004 || imem_req !== 1'b1) begin errors++; $display("FAIL stream_addr1: got %h/%b expected 80000004/1", imem_addr, imem_req); end
    imem_rdata = 32'h1111_0001;
    tick;
    checks++; if (inst !== 32'h1111_0001) begin errors++; $display("FAIL stream_inst2: got %h expected 11110001", inst); end
    checks++; if (imem_addr !== 32'h8000_0008) begin errors++; $display("FAIL stream_addr2: got %h expected 80000008", imem_addr); end
    imem_rdata = 32'h1111_0002;
    tick;
    checks++; if (pc_plus_four !== 32'h8000_000C) begin errors++; $display("FAIL stream_ppf3: got %h expected 8000000c", pc_plus_four); end
    imem_ack = 1'b0;
  endtask

  task automatic test_hold;
    do_reset;
    imem_ack = 1'b1; imem_rdata = 32'hA000_0000; stall = 1'b0;
    tick;
    imem_rdata = 32'hA000_0001; stall = 1'b1;
    tick;
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %b expected 0", i, imem_req); end
      checks++; if (inst !== 32'hA000_0000 || inst_valid !== 1'b1) begin errors++; $display("FAIL hold_inst[%0d]: got %h/%b expected a0000000/1", i, inst, inst_valid); end
      if (i == 2) stall = 1'b0;
      tick;
    end
    checks++; if (inst !== 32'hA000_0001 || inst_valid !== 1'b1) begin errors++; $display("FAIL hold_release_inst: got %h/%b expected a0000001/1", inst, inst_valid); end
    checks++; if (pc_plus_four !== 32'h8000_0008) begin errors++; $display("FAIL hold_release_ppf: got %h expected 80000008", pc_plus_four); end
    checks++; if (imem_addr !== 32'h8000_0008 || imem_req !== 1'b1) begin errors++; $display("FAIL hold_release_addr: got %h/%b expected 80000008/1", imem_addr, imem_req); end
  endtask

  task automatic test_branch_drop;
    do_reset;
    imem_ack = 1'b0; pc_sel = 3'd1; branch_addr = 32'h0000_0100;
    tick;
    pc_sel = 3'd0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req1: got %b expected 0", imem_req); end
    tick;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req2: got %b expected 0", imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin errors++; $display("FAIL drop_discard: got %h/%b expected %h/0", inst, inst_valid, NOP); end
    checks++; if (imem_addr !== EXP_BRANCH || imem_req !== 1'b1) begin errors++; $display("FAIL drop_target: got %h/%b expected %h/1", imem_addr, imem_req, EXP_BRANCH); end
    imem_ack = 1'b1; imem_rdata = 32'hB000_0000;
    tick;
    imem_ack = 1'b0;
    checks++; if (inst !== 32'hB000_0000 || pc_plus_four !== EXP_BRANCH + 32'd4) begin errors++; $display("FAIL drop_next: got %h/%h expected b0000000/%h", inst, pc_plus_four, EXP_BRANCH + 32'd4); end
  endtask

  task automatic test_redirect_targets;
    do_reset;
    imem_ack = 1'b1; pc_sel = 3'd2; jump_addr = 32'h0000_0043; imem_rdata = 32'hCCCC_0000;
    tick;
    checks++; if (imem_addr !== 32'h0000_0040 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL jump_same_ack: got %h/%b/%b expected 00000040/1/0", imem_addr, imem_req, inst_valid); end
    jump_addr = 32'h8000_0010;
    tick;
    checks++; if (imem_addr !== EXP_JUMP) begin errors++; $display("FAIL jump_super: got %h expected %h", imem_addr, EXP_JUMP); end
    pc_sel = 3'd3;
    tick;
    checks++; if (imem_addr !== 32'h8000_0004) begin errors++; $display("FAIL illop: got %h expected 80000004", imem_addr); end
    pc_sel = 3'd2; jump_addr = 32'h7FFF_FFFC;
    tick;
    checks++; if (imem_addr !== 32'h7FFF_FFFC) begin errors++; $display("FAIL jump_edge: got %h expected 7ffffffc", imem_addr); end
    pc_sel = 3'd6; imem_rdata = 32'hCCCC_0001;
    tick;
    imem_ack = 1'b0; pc_sel = 3'd0;
    checks++; if (inst !== 32'hCCCC_0001 || inst_valid !== 1'b1) begin errors++; $display("FAIL sel6_inc_inst: got %h/%b expected cccc0001/1", inst, inst_valid); end
    checks++; if (pc_plus_four !== EXP_WRAP || imem_addr !== EXP_WRAP) begin errors++; $display("FAIL inc_wrap: got %h/%h expected %h", pc_plus_four, imem_addr, EXP_WRAP); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
    tick;
    imem_ack = 1'b0;
    tick;
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL midrst_async: got %b/%b expected 0/0", imem_req, inst_valid); end
    tick;
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_noreq: got %b expected 0", imem_req); end
    tick;
    imem_ack = 1'b0;
    checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin errors++; $display("FAIL midrst_discard: got %h/%b expected %h/0", inst, inst_valid, NOP); end
    checks++; if (imem_addr !== 32'h8000_0000 || imem_req !== 1'b1) begin errors++; $display("FAIL midrst_refetch: got %h/%b expected 80000000/1", imem_addr, imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hE000_0001;
    tick;
    imem_ack = 1'b0;
    checks++; if (inst !== 32'hE000_0001 || pc_plus_four !== 32'h8000_0004) begin errors++; $display("FAIL midrst_next: got %h/%h expected e0000001/80000004", inst, pc_plus_four); end
  endtask

  task automatic test_xadr_hold;
    do_reset;
    imem_ack = 1'b1; stall = 1'b1; imem_rdata = 32'hF000_0000;
    tick;
    imem_ack = 1'b0; pc_sel = 3'd4;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL xadr_hold_req: got %b expected 0", imem_req); end
    tick;
    pc_sel = 3'd0; stall = 1'b0;
    checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin errors++; $display("FAIL xadr_discard: got %h/%b expected %h/0", inst, inst_valid, NOP); end
    checks++; if (imem_addr !== 32'h8000_0008 || imem_req !== 1'b1) begin errors++; $display("FAIL xadr_addr: got %h/%b expected 80000008/1", imem_addr, imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'hF000_0001;
    tick;
    imem_ack = 1'b0;
    checks++; if (inst !== 32'hF000_0001 || pc_plus_four !== 32'h8000_000C) begin errors++; $display("FAIL xadr_next: got %h/%h expected f0000001/8000000c", inst, pc_plus_four); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_hold;
    test_branch_drop;
    test_redirect_targets;
    test_reset_mid;
    test_xadr_hold;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
